// File: rtl/neuron_sched_pkg.sv
// Shared sizing, reset constants, config addresses and FSM encoding for the LIF neuron scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package neuron_sched_pkg;
    localparam int N_STAGES  = 5;
    localparam int INPUTS    = 2 ** N_STAGES;
    localparam int OUT_PREC  = N_STAGES + 2;
    localparam int N_NEURONS = 4;
    localparam int BYTES     = INPUTS / 8;
    localparam int IDX_W     = $clog2(N_NEURONS);
    localparam int BSEL_W    = $clog2(BYTES);
    localparam int ADDR_W    = IDX_W + BSEL_W + 1;

    localparam logic [OUT_PREC-1:0] RESET_MINUS_TETA = OUT_PREC'(-5);

    // Global config lives in the upper half of the address map; only these two
    // exact addresses are decoded, everything else up there is ignored.
    localparam logic [ADDR_W-1:0] CFG_TETA  = ADDR_W'(1 << (ADDR_W - 1));
    localparam logic [ADDR_W-1:0] CFG_SHIFT = CFG_TETA | ADDR_W'(1);

    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
        REPORT
    } sched_state_t;
endpackage

// File: rtl/neuron_state_bank.sv
// Per-neuron weight / membrane / spike register file: one read port, one state write, one byte weight write.
// Latency: reads are combinational from registers; writes visible the cycle after.
// Backpressure: none; writes always accepted, clear zeroes U/S and keeps weights.
// Ports: rd_* read port; st_* state write-back; w_* byte-wide weight write; clear soft reset.
module neuron_state_bank
    import neuron_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [INPUTS-1:0]   rd_w,
    output logic [OUT_PREC-1:0] rd_u,
    output logic                rd_s,
    input  logic                st_we,
    input  logic [IDX_W-1:0]    st_idx,
    input  logic [OUT_PREC-1:0] st_u,
    input  logic                st_s,
    input  logic                w_we,
    input  logic [IDX_W-1:0]    w_idx,
    input  logic [BSEL_W-1:0]   w_byte,
    input  logic [7:0]          w_data
);
    logic [INPUTS-1:0]   w_mem [N_NEURONS];
    logic [OUT_PREC-1:0] u_mem [N_NEURONS];
    logic [N_NEURONS-1:0] s_mem;

    // Weights survive clear; only reset wipes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) w_mem[i] <= '0;
        end else if (w_we) begin
            w_mem[w_idx][{w_byte, 3'b000} +: 8] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) u_mem[i] <= '0;
            s_mem <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) u_mem[i] <= '0;
            s_mem <= '0;
        end else if (st_we) begin
            u_mem[st_idx] <= st_u;
            s_mem[st_idx] <= st_s;
        end
    end

    assign rd_w = w_mem[rd_idx];
    assign rd_u = u_mem[rd_idx];
    assign rd_s = s_mem[rd_idx];
endmodule

// File: rtl/neuron_tmux_scheduler.sv
// Time-multiplexes one shared LIF datapath over N_NEURONS virtual neurons, one neuron per cycle.
// Latency: BYTES accepted input cycles + N_NEURONS eval cycles + 1 report cycle per timestep.
// Backpressure: in_ready only in COLLECT; the source holds its byte during EVAL/REPORT.
// Ports: in_* serial spike bytes; cfg_* weight/threshold/leak writes; nrn_* shared datapath
// interface; spike_valid/spike_vec per-timestep result; busy while evaluating or reporting.
module neuron_tmux_scheduler
    import neuron_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [7:0]           cfg_data,
    input  logic                 clear,
    output logic [INPUTS-1:0]    nrn_w,
    output logic [INPUTS-1:0]    nrn_x,
    output logic [2:0]           nrn_shift,
    output logic [OUT_PREC-1:0]  nrn_minus_teta,
    output logic [OUT_PREC-1:0]  nrn_prev_u,
    output logic                 nrn_was_spike,
    input  logic [OUT_PREC-1:0]  nrn_u_out,
    input  logic                 nrn_spike,
    output logic                 spike_valid,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 busy
);
    sched_state_t         state;
    logic [BSEL_W-1:0]    bcnt;
    logic [IDX_W-1:0]     idx;
    logic [INPUTS-1:0]    x;
    logic [N_NEURONS-1:0] spike_vec_next;
    logic [OUT_PREC-1:0]  minus_teta;
    logic [2:0]           shift;

    logic                 in_eval;
    logic [IDX_W-1:0]     rd_idx;
    logic                 w_we;

    assign in_eval  = (state == EVAL);
    assign in_ready = (state == COLLECT);
    assign busy     = (state == EVAL) || (state == REPORT);

    // Outside EVAL the datapath always sees neuron 0 so its inputs stay quiet.
    assign rd_idx = in_eval ? idx : '0;
    assign w_we   = cfg_we && !cfg_addr[ADDR_W-1];

    neuron_state_bank u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .rd_idx (rd_idx),
        .rd_w   (nrn_w),
        .rd_u   (nrn_prev_u),
        .rd_s   (nrn_was_spike),
        .st_we  (in_eval && !clear),
        .st_idx (idx),
        .st_u   (nrn_u_out),
        .st_s   (nrn_spike),
        .w_we   (w_we),
        .w_idx  (cfg_addr[ADDR_W-2:BSEL_W]),
        .w_byte (cfg_addr[BSEL_W-1:0]),
        .w_data (cfg_data)
    );

    // Global config is independent of the FSM and of clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minus_teta <= RESET_MINUS_TETA;
            shift      <= 3'd0;
        end else if (cfg_we) begin
            if (cfg_addr == CFG_TETA)  minus_teta <= cfg_data[OUT_PREC-1:0];
            if (cfg_addr == CFG_SHIFT) shift      <= cfg_data[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= COLLECT;
            bcnt           <= '0;
            idx            <= '0;
            x              <= '0;
            spike_vec      <= '0;
            spike_vec_next <= '0;
            spike_valid    <= 1'b0;
        end else if (clear) begin
            // Aborts any timestep in flight; a byte offered this cycle is dropped.
            state          <= COLLECT;
            bcnt           <= '0;
            idx            <= '0;
            x              <= '0;
            spike_vec      <= '0;
            spike_vec_next <= '0;
            spike_valid    <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        x <= {x[INPUTS-9:0], in_data};
                        if (bcnt == BSEL_W'(BYTES - 1)) begin
                            bcnt  <= '0;
                            idx   <= '0;
                            state <= EVAL;
                        end else begin
                            bcnt <= bcnt + BSEL_W'(1);
                        end
                    end
                end
                EVAL: begin
                    spike_vec_next[idx] <= nrn_spike;
                    // N_NEURONS is a power of two, so the index wraps back to 0.
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N_NEURONS - 1)) state <= REPORT;
                end
                REPORT: begin
                    spike_vec   <= spike_vec_next;
                    spike_valid <= 1'b1;
                    bcnt        <= '0;
                    state       <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign nrn_x          = x;
    assign nrn_shift      = shift;
    assign nrn_minus_teta = minus_teta;
endmodule
